// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared by the control sequencer, its bus interface
// and the bus monitor of the 8-bit CPU model.
//   - control-word bit indices and width
//   - opcode values and the opcode-defined check
//   - sequencer state encoding
//   - binary phase numbers and the one-hot T0 pattern of the phase ring
package cpu_defs;

    localparam int CTRL_W = 12;

    // Control-word bit positions
    localparam int PC_INC   = 0;
    localparam int PC_OUT   = 1;
    localparam int MAR_LOAD = 2;
    localparam int RAM_OUT  = 3;
    localparam int IR_LOAD  = 4;
    localparam int IR_OUT   = 5;
    localparam int ACC_LOAD = 6;
    localparam int ACC_OUT  = 7;
    localparam int B_LOAD   = 8;
    localparam int ALU_OUT  = 9;
    localparam int ALU_SUB  = 10;
    localparam int OUT_LOAD = 11;

    // Opcodes (upper nibble of the instruction byte)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OUT = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Binary phase numbers used by the decoder
    localparam logic [2:0] PH_T0 = 3'd0;
    localparam logic [2:0] PH_T1 = 3'd1;
    localparam logic [2:0] PH_T2 = 3'd2;
    localparam logic [2:0] PH_T3 = 3'd3;
    localparam logic [2:0] PH_T4 = 3'd4;
    localparam logic [2:0] PH_T7 = 3'd7;

    // Ring value that marks T0 of an instruction
    localparam logic [7:0] T0_PATTERN = 8'h80;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Legal successor of a ring value: one left rotation
    function automatic logic [7:0] ring_next(input logic [7:0] s);
        return {s[6:0], s[7]};
    endfunction

    // Every opcode outside this set decodes as a NOP and flags illegal_op
    function automatic logic op_defined(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_LDA) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: bundle between the timing-signal generator / instruction bus
// and the control sequencer.
//   signals    : one-hot phase ring from the generator
//   ir_data    : instruction byte from the bus
//   ctrl       : control word for the current phase
//   phase      : binary phase of signals (0 when not one-hot)
//   sg_rst_n   : active-low restart request to the generator
//   fault      : sequencer is in FAULT
//   err        : sticky ring-error flag
//   halted     : sequencer is in HALT
//   illegal_op : T2 pulse for an undefined opcode
//   instr_done : T7 pulse of a running instruction
// master = generator/bus side, slave = sequencer side.
interface ctrl_seq_if;
    import cpu_defs::*;

    logic [7:0]        signals;
    logic [7:0]        ir_data;
    logic [CTRL_W-1:0] ctrl;
    logic [2:0]        phase;
    logic              sg_rst_n;
    logic              fault;
    logic              err;
    logic              halted;
    logic              illegal_op;
    logic              instr_done;

    modport master (
        output signals, ir_data,
        input  ctrl, phase, sg_rst_n, fault, err, halted, illegal_op, instr_done
    );

    modport slave (
        input  signals, ir_data,
        output ctrl, phase, sg_rst_n, fault, err, halted, illegal_op, instr_done
    );

endinterface

// File: rtl/phase_enc.sv
// phase_enc: one-hot phase ring to binary phase encoder.
//   onehot : ring value (bit7=T0, bit0=T1, ... bit6=T7)
//   phase  : binary phase number, 0 when onehot is not exactly one-hot
//   valid  : exactly one bit of onehot is set
// Purely combinational; shared with the bus monitor.
module phase_enc (
    input  logic [7:0] onehot,
    output logic [2:0] phase,
    output logic       valid
);

    always_comb begin
        // x & (x-1) clears the lowest set bit: zero result means at most one bit
        valid = (onehot != 8'd0) && ((onehot & (onehot - 8'd1)) == 8'd0);
        phase = 3'd0;
        for (int i = 0; i < 8; i++) begin
            // bit i is phase i+1; bit7 wraps around to T0
            if (onehot[i]) begin
                phase = 3'(i + 1);
            end
        end
        if (!valid) begin
            phase = 3'd0;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: control sequencer of the 8-bit CPU model.
// Follows the one-hot phase ring of the timing-signal generator, checks that
// it advances by exactly one rotation per clock, latches the opcode at the
// end of T1 and decodes opcode x phase into the control word.
// A broken ring sends the sequencer into a 2-cycle FAULT that holds the
// generator in restart (sg_rst_n low), after which it resynchronises on T0.
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high
//   bus : ctrl_seq_if slave (ring/instruction in, control word and status out)
// ctrl, phase, illegal_op and instr_done are combinational from the ring,
// state and opcode register; sg_rst_n, fault, err and halted are registered.
module ctrl_seq
    import cpu_defs::*;
(
    input logic        clk,
    input logic        rst,
    ctrl_seq_if.slave  bus
);

    state_e      state_q, state_d;
    logic [7:0]  prev_sig_q, prev_sig_d;
    logic [3:0]  opcode_q, opcode_d;
    logic        fault_cnt_q, fault_cnt_d;
    logic        sg_rst_n_q, sg_rst_n_d;
    logic        fault_q, fault_d;
    logic        err_q, err_d;
    logic        halted_q, halted_d;

    logic [2:0]  enc_phase;
    logic        enc_valid;
    logic        ring_ok;
    logic        sync_hit;

    logic [CTRL_W-1:0] ctrl_w;
    logic              illegal_w;
    logic              done_w;

    // Operand nibble is consumed by the datapath, not by the sequencer
    logic unused_ir_lo;
    assign unused_ir_lo = ^bus.ir_data[3:0];

    phase_enc u_phase_enc (
        .onehot (bus.signals),
        .phase  (enc_phase),
        .valid  (enc_valid)
    );

    // Only meaningful in RUN, where prev_sig_q always holds a one-hot value
    assign ring_ok  = enc_valid && (bus.signals == ring_next(prev_sig_q));
    assign sync_hit = (bus.signals == T0_PATTERN);

    function automatic logic [CTRL_W-1:0] microcode(input logic [3:0] op,
                                                    input logic [2:0] ph);
        logic [CTRL_W-1:0] w;
        w = '0;
        case (ph)
            PH_T0: begin
                w[PC_OUT]   = 1'b1;
                w[MAR_LOAD] = 1'b1;
            end
            PH_T1: begin
                w[RAM_OUT]  = 1'b1;
                w[IR_LOAD]  = 1'b1;
                w[PC_INC]   = 1'b1;
            end
            PH_T2: begin
                if ((op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB)) begin
                    w[IR_OUT]   = 1'b1;
                    w[MAR_LOAD] = 1'b1;
                end else if (op == OP_OUT) begin
                    w[ACC_OUT]  = 1'b1;
                    w[OUT_LOAD] = 1'b1;
                end
            end
            PH_T3: begin
                if (op == OP_LDA) begin
                    w[RAM_OUT]  = 1'b1;
                    w[ACC_LOAD] = 1'b1;
                end else if ((op == OP_ADD) || (op == OP_SUB)) begin
                    w[RAM_OUT]  = 1'b1;
                    w[B_LOAD]   = 1'b1;
                end
            end
            PH_T4: begin
                if ((op == OP_ADD) || (op == OP_SUB)) begin
                    w[ALU_OUT]  = 1'b1;
                    w[ACC_LOAD] = 1'b1;
                    w[ALU_SUB]  = (op == OP_SUB);
                end
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            prev_sig_q  <= '0;
            opcode_q    <= '0;
            fault_cnt_q <= 1'b0;
            sg_rst_n_q  <= 1'b1;
            fault_q     <= 1'b0;
            err_q       <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_sig_q  <= prev_sig_d;
            opcode_q    <= opcode_d;
            fault_cnt_q <= fault_cnt_d;
            sg_rst_n_q  <= sg_rst_n_d;
            fault_q     <= fault_d;
            err_q       <= err_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        fault_cnt_d = fault_cnt_q;
        err_d       = err_q;
        prev_sig_d  = bus.signals;

        case (state_q)
            ST_SYNC: begin
                if (sync_hit) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!ring_ok) begin
                    state_d     = ST_FAULT;
                    fault_cnt_d = 1'b0;
                    opcode_d    = '0;
                    err_d       = 1'b1;
                end else begin
                    if (enc_phase == PH_T1) begin
                        opcode_d = bus.ir_data[7:4];
                    end
                    if ((enc_phase == PH_T2) && (opcode_q == OP_HLT)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                // Two FAULT cycles: counter 0 then 1, then back to SYNC
                fault_cnt_d = 1'b1;
                if (fault_cnt_q) begin
                    state_d = ST_SYNC;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        // Status flags are registered images of the state being entered
        sg_rst_n_d = (state_d != ST_FAULT);
        fault_d    = (state_d == ST_FAULT);
        halted_d   = (state_d == ST_HALT);
    end

    // Output decode
    always_comb begin
        ctrl_w    = '0;
        illegal_w = 1'b0;
        done_w    = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (sync_hit) begin
                    ctrl_w = microcode(opcode_q, PH_T0);
                end
            end
            ST_RUN: begin
                if (ring_ok) begin
                    ctrl_w    = microcode(opcode_q, enc_phase);
                    illegal_w = (enc_phase == PH_T2) && !op_defined(opcode_q);
                    done_w    = (enc_phase == PH_T7);
                end
            end
            default: begin
                ctrl_w = '0;
            end
        endcase

        if (rst) begin
            ctrl_w    = '0;
            illegal_w = 1'b0;
            done_w    = 1'b0;
        end
    end

    assign bus.ctrl       = ctrl_w;
    assign bus.phase      = rst ? 3'd0 : enc_phase;
    assign bus.illegal_op = illegal_w;
    assign bus.instr_done = done_w;
    assign bus.sg_rst_n   = sg_rst_n_q;
    assign bus.fault      = fault_q;
    assign bus.err        = err_q;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed bench for ctrl_seq with a phase-level reference model.
module tb_ctrl_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_seq_if bus ();

    ctrl_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ring value shown during phase t
    function automatic logic [7:0] ring_at(input int t);
        return (t == 0) ? 8'h80 : 8'(8'h01 << (t - 1));
    endfunction

    // Phase index of a ring value, -1 when it is not a legal ring value
    function automatic int phase_of(input logic [7:0] s);
        for (int t = 0; t < 8; t++) begin
            if (s == ring_at(t)) return t;
        end
        return -1;
    endfunction

    // Control word table by opcode and phase
    function automatic logic [11:0] ucode(input logic [3:0] op, input int t);
        case (t)
            0: return 12'h006;
            1: return 12'h019;
            2: begin
                if (op == 4'h1 || op == 4'h2 || op == 4'h3) return 12'h024;
                if (op == 4'h4) return 12'h880;
                return 12'h000;
            end
            3: begin
                if (op == 4'h1) return 12'h048;
                if (op == 4'h2 || op == 4'h3) return 12'h108;
                return 12'h000;
            end
            4: begin
                if (op == 4'h2) return 12'h240;
                if (op == 4'h3) return 12'h640;
                return 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    function automatic bit known_op(input logic [3:0] op);
        return (op <= 4'h4) || (op == 4'hF);
    endfunction

    // Reference model: 0 SYNC, 1 RUN, 2 HALT, 3 FAULT
    int         m_mode = 0;
    logic [7:0] m_prev = 8'h00;
    logic [3:0] m_op   = 4'h0;
    int         m_left = 0;
    bit         m_err  = 1'b0;

    always @(negedge clk) begin : model
        int         t, pp;
        logic [11:0] e_ctrl;
        logic       e_ill, e_done;
        logic [2:0] e_phase;
        if (chk_en) begin
            t       = phase_of(bus.signals);
            e_ctrl  = 12'h000;
            e_ill   = 1'b0;
            e_done  = 1'b0;
            e_phase = (t < 0) ? 3'd0 : 3'(t);

            chk("fault",    32'(bus.fault),    32'(m_mode == 3));
            chk("sg_rst_n", 32'(bus.sg_rst_n), 32'(m_mode != 3));
            chk("halted",   32'(bus.halted),   32'(m_mode == 2));
            chk("err",      32'(bus.err),      32'(m_err));

            if (rst) begin
                e_phase = 3'd0;
                m_mode  = 0;
                m_prev  = 8'h00;
                m_op    = 4'h0;
                m_left  = 0;
                m_err   = 1'b0;
            end else begin
                case (m_mode)
                    0: begin
                        if (bus.signals == 8'h80) begin
                            e_ctrl = ucode(m_op, 0);
                            m_mode = 1;
                        end
                    end
                    1: begin
                        pp = phase_of(m_prev);
                        if (pp >= 0 && t >= 0 && t == (pp + 1) % 8) begin
                            e_ctrl = ucode(m_op, t);
                            e_ill  = (t == 2) && !known_op(m_op);
                            e_done = (t == 7);
                            if (t == 2 && m_op == 4'hF) m_mode = 2;
                            if (t == 1) m_op = bus.ir_data[7:4];
                        end else begin
                            m_mode = 3;
                            m_left = 2;
                            m_op   = 4'h0;
                            m_err  = 1'b1;
                        end
                    end
                    3: begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_mode = 0;
                    end
                    default: ;
                endcase
                m_prev = bus.signals;
            end

            chk("ctrl",       32'(bus.ctrl),       32'(e_ctrl));
            chk("phase",      32'(bus.phase),      32'(e_phase));
            chk("illegal_op", 32'(bus.illegal_op), 32'(e_ill));
            chk("instr_done", 32'(bus.instr_done), 32'(e_done));
        end
    end

    task automatic drive(input logic [7:0] s, input logic [7:0] ir, input logic r);
        @(posedge clk);
        #1;
        bus.signals = s;
        bus.ir_data = ir;
        rst = r;
    endtask

    logic [11:0] lda_exp [8] = '{12'h006, 12'h019, 12'h024, 12'h048,
                                 12'h000, 12'h000, 12'h000, 12'h000};

    initial begin
        bus.signals = 8'h00;
        bus.ir_data = 8'h00;

        // Reset
        drive(8'h00, 8'h00, 1'b1);
        drive(8'h00, 8'h00, 1'b1);
        chk_en = 1'b1;
        drive(8'h01, 8'h00, 1'b1);
        #2;
        chk("rst_ctrl", 32'(bus.ctrl), 32'h0);
        chk("rst_phase", 32'(bus.phase), 32'h0);
        chk("rst_sg_rst_n", 32'(bus.sg_rst_n), 32'h1);
        chk("rst_err", 32'(bus.err), 32'h0);

        // Idle in SYNC, including a non-T0 ring value
        drive(8'h00, 8'h00, 1'b0);
        drive(8'h01, 8'h00, 1'b0);
        #2;
        chk("sync_idle_ctrl", 32'(bus.ctrl), 32'h0);
        chk("sync_idle_phase", 32'(bus.phase), 32'h1);

        // LDA
        for (int t = 0; t < 8; t++) begin
            drive(ring_at(t), 8'h1E, 1'b0);
            #2;
            chk($sformatf("lda_t%0d", t), 32'(bus.ctrl), 32'(lda_exp[t]));
            chk($sformatf("lda_done_t%0d", t), 32'(bus.instr_done), 32'(t == 7));
        end

        // SUB
        for (int t = 0; t < 8; t++) begin
            drive(ring_at(t), 8'h3A, 1'b0);
            #2;
            if (t == 3) chk("sub_t3", 32'(bus.ctrl), 32'h108);
            if (t == 4) chk("sub_t4", 32'(bus.ctrl), 32'h640);
        end

        // ADD then OUT
        for (int t = 0; t < 8; t++) drive(ring_at(t), 8'h25, 1'b0);
        for (int t = 0; t < 8; t++) begin
            drive(ring_at(t), 8'h40, 1'b0);
            #2;
            if (t == 2) chk("out_t2", 32'(bus.ctrl), 32'h880);
        end

        // Illegal opcode then NOP
        for (int t = 0; t < 8; t++) begin
            drive(ring_at(t), 8'h70, 1'b0);
            #2;
            chk($sformatf("ill_pulse_t%0d", t), 32'(bus.illegal_op), 32'(t == 2));
            if (t >= 2) chk($sformatf("ill_ctrl_t%0d", t), 32'(bus.ctrl), 32'h0);
        end
        for (int t = 0; t < 8; t++) begin
            drive(ring_at(t), 8'h00, 1'b0);
            #2;
            if (t == 0) chk("nop_t0", 32'(bus.ctrl), 32'h006);
        end

        // Broken ring at T3 of an LDA
        for (int t = 0; t < 3; t++) drive(ring_at(t), 8'h1E, 1'b0);
        drive(8'h03, 8'h1E, 1'b0);
        #2;
        chk("brk_ctrl", 32'(bus.ctrl), 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive(8'h00, 8'h1E, 1'b0);
            #2;
            chk($sformatf("flt_fault_%0d", k), 32'(bus.fault), 32'h1);
            chk($sformatf("flt_sg_rst_n_%0d", k), 32'(bus.sg_rst_n), 32'h0);
        end
        drive(8'h80, 8'h1E, 1'b0);
        #2;
        chk("rec_t0", 32'(bus.ctrl), 32'h006);
        chk("rec_fault", 32'(bus.fault), 32'h0);
        chk("rec_err", 32'(bus.err), 32'h1);
        for (int t = 1; t < 8; t++) drive(ring_at(t), 8'h1E, 1'b0);

        // Reset during T3..T4 of an ADD
        for (int t = 0; t < 8; t++) begin
            drive(ring_at(t), 8'h2C, (t == 3 || t == 4));
            #2;
            if (t >= 3) chk($sformatf("rst_mid_t%0d", t), 32'(bus.ctrl), 32'h0);
        end
        chk("rst_mid_err", 32'(bus.err), 32'h0);
        for (int t = 0; t < 8; t++) begin
            drive(ring_at(t), 8'h2C, 1'b0);
            #2;
            if (t == 0) chk("resume_t0", 32'(bus.ctrl), 32'h006);
            if (t == 4) chk("resume_t4", 32'(bus.ctrl), 32'h240);
        end

        // HLT
        for (int t = 0; t < 3; t++) begin
            drive(ring_at(t), 8'hF0, 1'b0);
            #2;
            if (t == 2) chk("hlt_t2", 32'(bus.ctrl), 32'h0);
        end
        for (int k = 0; k < 21; k++) begin
            drive(ring_at((3 + k) % 8), 8'h1E, 1'b0);
            #2;
            chk($sformatf("hlt_halted_%0d", k), 32'(bus.halted), 32'h1);
            chk($sformatf("hlt_ctrl_%0d", k), 32'(bus.ctrl), 32'h0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Control sequencer that consumes the 8-bit one-hot phase ring from the timing-signal generator and turns it into the per-phase control word of the 8-bit CPU model. It validates that the ring advances by exactly one rotation per clock, latches the opcode during fetch, and decodes opcode × phase into control strobes. On a broken ring it forces a generator restart through an active-low reset line.

## Interface
- No parameters; widths are fixed by the CPU model.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- signals  in  8  one-hot phase ring from the generator. Phase map: bit7=T0, bit0=T1, bit1=T2, …, bit6=T7. The legal successor of `s` is `{s[6:0],s[7]}`.
- ir_data  in  8  instruction byte from the bus. Opcode is `ir_data[7:4]`.
- ctrl  out  12  control word. Bit assignments:
  - 0 pc_inc, 1 pc_out, 2 mar_load, 3 ram_out
  - 4 ir_load, 5 ir_out, 6 acc_load, 7 acc_out
  - 8 b_load, 9 alu_out, 10 alu_sub, 11 out_load
- phase  out  3  binary phase of `signals`; 0 when `signals` is not one-hot.
- sg_rst_n  out  1  active-low restart request to the generator.
- fault  out  1  high while in FAULT.
- err  out  1  sticky ring-error flag; cleared only by rst.
- halted  out  1  high in HALT.
- illegal_op  out  1  one-cycle pulse at T2 for an undefined opcode.
- instr_done  out  1  one-cycle pulse during T7 in RUN.

## Operation
States: SYNC, RUN, HALT, FAULT.

Opcodes:
- 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 OUT, F HLT.
- All others: illegal; executed as NOP.

State behaviour:
- SYNC
  - ctrl=0 except when `signals==8'h80`.
  - On 8'h80, that cycle is T0 of the first instruction: the T0 word is driven and the next state is RUN.
- RUN
  - Each cycle, `signals` must equal the rotation of the previous cycle's `signals`, held in a `prev_sig` register that loads every cycle.
  - On a mismatch (including 0 or multi-hot): ctrl=0 and instr_done=0 in that cycle, err set, next state FAULT.
  - Otherwise decode per the microcode below.
- HALT: ctrl=0; `signals` is ignored; stays until rst.
- FAULT
  - Lasts exactly 2 cycles with fault=1 and sg_rst_n=0, then goes to SYNC.
  - The opcode register is cleared on entry.

Microcode (ctrl bits asserted per phase):
- T0: pc_out, mar_load.
- T1: ram_out, ir_load, pc_inc. The opcode register captures `ir_data[7:4]` at the end of T1.
- T2:
  - LDA/ADD/SUB: ir_out, mar_load.
  - OUT: acc_out, out_load.
  - HLT: none; next state HALT.
  - Illegal: illegal_op=1.
- T3:
  - LDA: ram_out, acc_load.
  - ADD/SUB: ram_out, b_load.
- T4:
  - ADD: alu_out, acc_load.
  - SUB: alu_out, acc_load, alu_sub.
- T5–T7: none. instr_done=1 in T7.

## Timing
- Reset values:
  - State SYNC; opcode and prev_sig = 0.
  - ctrl=0, phase=0 while rst is high.
  - sg_rst_n=1, fault=0, err=0, halted=0, illegal_op=0, instr_done=0.
- ctrl, phase, illegal_op and instr_done are combinational from the current `signals`, state and opcode register. They have zero latency relative to the phase.
- sg_rst_n, fault, halted and err are registered, so each changes on the edge after its cause.
- Fault recovery: the mismatch cycle is C; FAULT covers C+1 and C+2 (sg_rst_n low). The generator then shows 8'h80, and SYNC decodes T0 in C+3 at the earliest.
- Reset mid-instruction: rst wins over every transition. The bench sees SYNC on the next cycle, and execution resumes at the next 8'h80, within ≤8 cycles.
- HLT detected in T2 → halted=1 from the following cycle, with ctrl=0 from T3 onward.

## Structure
- Shared package/header `cpu_defs` holds:
  - ctrl bit indices, CTRL_W=12
  - opcode constants
  - state encoding
  - T0_PATTERN=8'h80
- Sub-module `phase_enc`: combinational one-hot→3-bit encoder plus a `valid` output (exactly one bit set). It is also reused by the bus monitor.

## Test plan
- Reset, then feed a clean ring with ir_data=8'h1E (LDA):
  - T0 ctrl=12'h006; T1=12'h019; T2=12'h024; T3=12'h048; T4–T7=0.
  - instr_done pulses in T7.
- ir_data=8'h3A (SUB): T3 ctrl=12'h108; T4 ctrl=12'h640.
- ir_data=8'hF0: halted=1 the cycle after T2; ctrl stays 0 for 20 further ring cycles.
- Inject `signals=8'h03` at T3: that cycle ctrl=0, then fault=1 and sg_rst_n=0 for exactly 2 cycles, err=1 sticky. After the generator restarts, the T0 word 12'h006 reappears.
- Assert rst during T3 of an ADD, release it at T5: ctrl=0 until the next 8'h80, then a normal fetch follows.
- ir_data=8'h70: illegal_op pulses one cycle at T2; T3–T7 ctrl=0; the next instruction proceeds normally.
